// File: rtl/apb_fifo_pkg.sv
// APB FIFO completer: register offsets, bit positions, FSM states.
// Shared by apb_fifo_mem and apb_fifo_slave.
package apb_fifo_pkg;

   localparam logic [11:0] OFF_CTRL   = 12'h000;
   localparam logic [11:0] OFF_STATUS = 12'h004;
   localparam logic [11:0] OFF_WDATA  = 12'h008;
   localparam logic [11:0] OFF_RDATA  = 12'h00C;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_UDF     = 3;
   localparam int STAT_CNT_LSB = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_e;

endpackage

// File: rtl/apb_fifo_mem.sv
// FIFO storage with wrapping read/write pointers and occupancy count.
// Storage is not reset; only pointers and count are.
module apb_fifo_mem
   import apb_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [DW-1:0]          din_i,
   output logic [DW-1:0]          dout_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + {{AW{1'b0}}, do_push}
                       - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push & ~flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer fronting a small FIFO (CTRL/STATUS/WDATA/RDATA).
// Define APB_FIFO_WAIT_EN to add one wait state to every transfer.
module apb_fifo_slave
   import apb_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic          PCLK,
   input  logic          PRESET,
   input  logic          PSEL,
   input  logic          PENABLE,
   input  logic          PWRITE,
   input  logic [31:0]   PADDR,
   input  logic [DW-1:0] PWDATA,
   output logic [DW-1:0] PRDATA,
   output logic          PREADY,
   output logic          irq_nempty
);

   localparam int CW = $clog2(DEPTH) + 1;

`ifdef APB_FIFO_WAIT_EN
   localparam state_e FIRST_ST = S_WAIT;
`else
   localparam state_e FIRST_ST = S_ACCESS;
`endif

   state_e  state_q;
   logic    en_q, ovf_q, udf_q;
   logic    is_ctrl, is_stat, is_wdat, is_rdat;
   logic    wr_done, rd_done;
   logic    push, pop, flush;
   logic    full, empty;
   logic [CW-1:0] count;
   logic [DW-1:0] dout, rdata;
   logic    unused_paddr;

   assign unused_paddr = ^PADDR[31:12];

   assign is_ctrl = (PADDR[11:0] == OFF_CTRL);
   assign is_stat = (PADDR[11:0] == OFF_STATUS);
   assign is_wdat = (PADDR[11:0] == OFF_WDATA);
   assign is_rdat = (PADDR[11:0] == OFF_RDATA);

   assign PREADY  = (state_q == S_ACCESS) & PSEL & PENABLE;
   assign wr_done = PREADY & PWRITE;
   assign rd_done = PREADY & ~PWRITE;

   assign push  = wr_done & is_wdat & en_q & ~full;
   assign pop   = rd_done & is_rdat & en_q & ~empty;
   assign flush = wr_done & is_ctrl & PWDATA[CTRL_FLUSH];

   assign irq_nempty = en_q & ~empty;

   apb_fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_mem (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   (PWDATA),
      .dout_o  (dout),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // Deselect in WAIT/ACCESS aborts the transfer without side effects.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:
               if (PSEL & ~PENABLE) state_q <= FIRST_ST;
            S_WAIT:
               state_q <= PSEL ? S_ACCESS : S_IDLE;
            S_ACCESS:
               if (~PSEL | PREADY) state_q <= S_IDLE;
            default:
               state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         en_q  <= 1'b0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_done & is_ctrl) en_q <= PWDATA[CTRL_EN];
         if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            if (wr_done & is_wdat & full)  ovf_q <= 1'b1;
            if (rd_done & is_rdat & empty) udf_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         is_ctrl: rdata[CTRL_EN] = en_q;
         is_stat: begin
            rdata[STAT_EMPTY] = empty;
            rdata[STAT_FULL]  = full;
            rdata[STAT_OVF]   = ovf_q;
            rdata[STAT_UDF]   = udf_q;
            rdata[STAT_CNT_LSB +: CW] = count;
         end
         is_rdat: if (en_q & ~empty) rdata = dout;
         default: rdata = '0;
      endcase
   end

   assign PRDATA = PREADY ? rdata : '0;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Randomized self-checking bench for apb_fifo_slave against a queue model.
// Wait-state expectation follows APB_FIFO_WAIT_EN.
module tb_apb_fifo_slave;

   localparam int DEPTH = 8;

`ifdef APB_FIFO_WAIT_EN
   localparam int EXP_W = 1;
`else
   localparam int EXP_W = 0;
`endif

   logic        PCLK = 0;
   logic        PRESET;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, irq_nempty;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mq[$];
   bit          m_en, m_ovf, m_udf;

   always #5 PCLK = ~PCLK;

   apb_fifo_slave #(.DEPTH(DEPTH), .DW(32)) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .irq_nempty (irq_nempty)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'(mq.size()) << 4;
      s[0] = (mq.size() == 0);
      s[1] = (mq.size() == DEPTH);
      s[2] = m_ovf;
      s[3] = m_udf;
      return s;
   endfunction

   task automatic m_reset();
      mq.delete();
      m_en  = 0;
      m_ovf = 0;
      m_udf = 0;
   endtask

   task automatic bus(input logic wr, input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd);
      int w;
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = wr;
      PADDR = a; PWDATA = wd;
      @(posedge PCLK); #1;
      PENABLE = 1;
      #1;
      w = 0;
      while (!PREADY && w < 8) begin
         @(posedge PCLK); #2;
         w++;
      end
      chk("pready_seen", 32'(PREADY), 32'd1);
      chk("wait_states", 32'(w), 32'(EXP_W));
      rd = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0;
      #1;
      chk("idle_prdata", PRDATA, 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a,
                           input logic [31:0] d);
      logic [31:0] rd;
      bus(1'b1, a, d, rd);
      case (a[11:0])
         12'h000: begin
            if (d[1]) begin
               mq.delete();
               m_ovf = 0;
               m_udf = 0;
            end
            m_en = d[0];
         end
         12'h008: begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else if (m_en) mq.push_back(d);
         end
         default: ;
      endcase
      chk("irq_w", 32'(irq_nempty),
          32'(m_en && mq.size() > 0));
   endtask

   task automatic do_read(input logic [31:0] a,
                          input string tag);
      logic [31:0] rd, exp;
      exp = 0;
      case (a[11:0])
         12'h000: exp = 32'(m_en);
         12'h004: exp = m_status();
         12'h00C: begin
            if (mq.size() == 0) m_udf = 1;
            else if (m_en) exp = mq.pop_front();
         end
         default: exp = 0;
      endcase
      bus(1'b0, a, 32'd0, rd);
      chk(tag, rd, exp);
      chk("irq_r", 32'(irq_nempty),
          32'(m_en && mq.size() > 0));
   endtask

   initial begin
      logic [31:0] d;
      int r;
      PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0;
      PADDR = 0; PWDATA = 0;
      m_reset();
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      chk("rst_irq", 32'(irq_nempty), 32'd0);
      PRESET = 0;

      do_read(32'h004, "rst_status");
      chk("rst_status_val", m_status(), 32'h1);

      do_write(32'h000, 32'h1);
      do_read(32'h000, "ctrl_rd");
      for (int i = 1; i <= 3; i++)
         do_write(32'h008, 32'hA5A5_0000 + 32'(i));
      do_read(32'h004, "stat3");
      for (int i = 0; i < 3; i++)
         do_read(32'h00C, "fifo_order");
      do_read(32'h004, "stat_empty");

      for (int i = 0; i < 9; i++)
         do_write(32'h008, 32'hB000_0000 + 32'(i));
      do_read(32'h004, "stat_full_ovf");
      for (int i = 0; i < 8; i++)
         do_read(32'h00C, "drain");
      do_read(32'h00C, "empty_rd");
      do_read(32'h004, "stat_udf");
      do_write(32'h000, 32'h3);
      do_read(32'h004, "stat_flush");

      for (int i = 0; i < 20; i++) begin
         do_write(32'h008, 32'hC000_0000 + 32'(i));
         do_read(32'h00C, "wrap_pop");
      end
      do_write(32'h008, 32'hDEAD_0001);
      do_read(32'h010, "unmapped_rd");
      do_write(32'h014, 32'h1234_5678);
      do_read(32'h004, "stat_after_unmap");

      do_write(32'h000, 32'h0);
      do_write(32'h008, 32'h0000_0077);
      do_read(32'h00C, "dis_rd");
      do_read(32'h004, "dis_stat");
      do_write(32'h000, 32'h1);
      do_read(32'h00C, "reen_rd");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 19);
         d = $urandom;
         if (r < 8)       do_write(32'h008, d);
         else if (r < 14) do_read(32'h00C, "rnd_pop");
         else if (r < 16) do_read(32'h004, "rnd_stat");
         else if (r == 16) do_read(32'h000, "rnd_ctrl");
         else if (r == 17) do_read(32'h018, "rnd_unmap");
         else if (r == 18) do_write(32'h01C, d);
         else do_write(32'h000, (d[3:0] == 0) ? 32'h3 : 32'h1);
      end

      do_write(32'h000, 32'h3);
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = 1;
      PADDR = 32'h008; PWDATA = 32'hFEED_0001;
      @(posedge PCLK); #1;
      PENABLE = 1;
`ifdef APB_FIFO_WAIT_EN
      @(posedge PCLK); #1;
`endif
      #1;
      PRESET = 1;
      m_reset();
      #1;
      chk("rst_mid_pready", 32'(PREADY), 32'd0);
      @(posedge PCLK); #1;
      chk("rst_next_pready", 32'(PREADY), 32'd0);
      PSEL = 0; PENABLE = 0;
      PRESET = 0;
      do_read(32'h004, "rst_mid_status");
      do_read(32'h000, "rst_mid_ctrl");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
